// File: rtl/cmdq_rdwr_sched.sv
// Weighted round-robin scheduler that merges the NLB engine read and write request
// streams onto one CCI-P command-queue port, with read credit and almost-full throttling.
module cmdq_rdwr_sched #(
  parameter int ADDR_LMT    = 20,
  parameter int RD_WEIGHT   = 2,
  parameter int WR_WEIGHT   = 2,
  parameter int MAX_RD_PEND = 512
) (
  input  logic                Clk_400,
  input  logic                SoftReset,

  input  logic                rw2ab_RdEn,
  input  logic [ADDR_LMT-1:0] rw2ab_RdAddr,
  input  logic [15:0]         rw2ab_RdTID,
  input  logic [1:0]          rw2ab_RdLen,
  output logic                ab2rw_RdSent,

  input  logic                rw2ab_WrEn,
  input  logic [ADDR_LMT-1:0] rw2ab_WrAddr,
  input  logic [15:0]         rw2ab_WrTID,
  input  logic [511:0]        rw2ab_WrDin,
  input  logic [1:0]          rw2ab_WrLen,
  input  logic                rw2ab_WrSop,
  output logic                ab2rw_WrSent,
  output logic                ab2rw_WrAlmFull,

  input  logic                cq_AlmFull,
  output logic                cq_Valid,
  output logic                cq_IsWr,
  output logic [ADDR_LMT-1:0] cq_Addr,
  output logic [15:0]         cq_TID,
  output logic [1:0]          cq_Len,
  output logic                cq_Sop,
  output logic [511:0]        cq_Data,

  input  logic                rd_RspValid,
  output logic [10:0]         sch_RdPend
);

  typedef enum logic {ARB, WR_LOCK} schedState_t;

  localparam logic [3:0]  RD_W     = 4'(RD_WEIGHT);
  localparam logic [3:0]  WR_W     = 4'(WR_WEIGHT);
  localparam logic [11:0] PEND_LMT = 12'(MAX_RD_PEND);

  schedState_t state, stateNext;
  logic        ptrWr, ptrWrNext;
  logic [3:0]  weightCnt, weightCntNext, cntInc;
  logic [1:0]  beatsLeft, beatsLeftNext;
  logic [10:0] rdPend, rdPendNext;
  logic        creditOk, rdOk, wrOk;
  logic        rdGrant, wrGrant;

  // Grants are suppressed while reset is held so no Sent strobe is ever lost.
  assign creditOk = ({1'b0, rdPend} + {10'd0, rw2ab_RdLen} + 12'd1) <= PEND_LMT;
  assign rdOk     = rw2ab_RdEn & ~cq_AlmFull & ~SoftReset & creditOk & (state == ARB);
  assign wrOk     = rw2ab_WrEn & ~cq_AlmFull & ~SoftReset & ((state == WR_LOCK) | rw2ab_WrSop);

  assign ab2rw_RdSent    = rdGrant;
  assign ab2rw_WrSent    = wrGrant;
  assign ab2rw_WrAlmFull = cq_AlmFull;
  assign sch_RdPend      = rdPend;

  always_comb begin
    stateNext     = state;
    ptrWrNext     = ptrWr;
    weightCntNext = weightCnt;
    beatsLeftNext = beatsLeft;
    rdGrant       = 1'b0;
    wrGrant       = 1'b0;
    cntInc        = weightCnt + 4'd1;
    case (state)
      ARB: begin
        if (rdOk && wrOk) begin
          rdGrant = ~ptrWr;
          wrGrant = ptrWr;
          if (cntInc >= (ptrWr ? WR_W : RD_W)) begin
            ptrWrNext     = ~ptrWr;
            weightCntNext = 4'd0;
          end else begin
            weightCntNext = cntInc;
          end
        end else if (rdOk) begin
          rdGrant       = 1'b1;
          ptrWrNext     = 1'b1;
          weightCntNext = 4'd1;
        end else if (wrOk) begin
          wrGrant       = 1'b1;
          ptrWrNext     = 1'b0;
          weightCntNext = 4'd1;
        end
        // Multi-beat packets hold the port until their last beat is granted.
        if (wrGrant && (rw2ab_WrLen != 2'd0)) begin
          stateNext     = WR_LOCK;
          beatsLeftNext = rw2ab_WrLen;
        end
      end
      WR_LOCK: begin
        if (wrOk) begin
          wrGrant       = 1'b1;
          beatsLeftNext = beatsLeft - 2'd1;
          if (beatsLeft == 2'd1) stateNext = ARB;
        end
      end
      default: stateNext = ARB;
    endcase
  end

  always_comb begin
    rdPendNext = rdPend;
    if (rdGrant) rdPendNext = rdPendNext + {9'd0, rw2ab_RdLen} + 11'd1;
    if (rd_RspValid && (rdPend != 11'd0)) rdPendNext = rdPendNext - 11'd1;
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      state     <= ARB;
      ptrWr     <= 1'b0;
      weightCnt <= 4'd0;
      beatsLeft <= 2'd0;
      rdPend    <= 11'd0;
    end else begin
      state     <= stateNext;
      ptrWr     <= ptrWrNext;
      weightCnt <= weightCntNext;
      beatsLeft <= beatsLeftNext;
      rdPend    <= rdPendNext;
    end
  end

  // Command fields only load on a grant; cq_Valid marks whether they are fresh.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      cq_Valid <= 1'b0;
      cq_IsWr  <= 1'b0;
      cq_Addr  <= '0;
      cq_TID   <= 16'd0;
      cq_Len   <= 2'd0;
      cq_Sop   <= 1'b0;
      cq_Data  <= '0;
    end else begin
      cq_Valid <= rdGrant | wrGrant;
      if (rdGrant) begin
        cq_IsWr <= 1'b0;
        cq_Addr <= rw2ab_RdAddr;
        cq_TID  <= rw2ab_RdTID;
        cq_Len  <= rw2ab_RdLen;
        cq_Sop  <= 1'b1;
        cq_Data <= '0;
      end else if (wrGrant) begin
        cq_IsWr <= 1'b1;
        cq_Addr <= rw2ab_WrAddr;
        cq_TID  <= rw2ab_WrTID;
        cq_Len  <= rw2ab_WrLen;
        cq_Sop  <= (state == ARB);
        cq_Data <= rw2ab_WrDin;
      end
    end
  end

endmodule

// File: tb/tb_cmdq_rdwr_sched.sv
// Directed plus randomized bench for cmdq_rdwr_sched, checked against a cycle-level
// behavioural model of the scheduling rules.
module tb_cmdq_rdwr_sched;

  localparam int ADDR_LMT = 20;
  localparam int RDW      = 2;
  localparam int WRW      = 2;
  localparam int MAXP     = 8;

  logic                Clk_400, SoftReset;
  logic                rw2ab_RdEn, ab2rw_RdSent;
  logic [ADDR_LMT-1:0] rw2ab_RdAddr, rw2ab_WrAddr, cq_Addr;
  logic [15:0]         rw2ab_RdTID, rw2ab_WrTID, cq_TID;
  logic [1:0]          rw2ab_RdLen, rw2ab_WrLen, cq_Len;
  logic                rw2ab_WrEn, rw2ab_WrSop, ab2rw_WrSent, ab2rw_WrAlmFull;
  logic [511:0]        rw2ab_WrDin, cq_Data;
  logic                cq_AlmFull, cq_Valid, cq_IsWr, cq_Sop, rd_RspValid;
  logic [10:0]         sch_RdPend;

  cmdq_rdwr_sched #(
    .ADDR_LMT(ADDR_LMT), .RD_WEIGHT(RDW), .WR_WEIGHT(WRW), .MAX_RD_PEND(MAXP)
  ) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset),
    .rw2ab_RdEn(rw2ab_RdEn), .rw2ab_RdAddr(rw2ab_RdAddr), .rw2ab_RdTID(rw2ab_RdTID),
    .rw2ab_RdLen(rw2ab_RdLen), .ab2rw_RdSent(ab2rw_RdSent),
    .rw2ab_WrEn(rw2ab_WrEn), .rw2ab_WrAddr(rw2ab_WrAddr), .rw2ab_WrTID(rw2ab_WrTID),
    .rw2ab_WrDin(rw2ab_WrDin), .rw2ab_WrLen(rw2ab_WrLen), .rw2ab_WrSop(rw2ab_WrSop),
    .ab2rw_WrSent(ab2rw_WrSent), .ab2rw_WrAlmFull(ab2rw_WrAlmFull),
    .cq_AlmFull(cq_AlmFull), .cq_Valid(cq_Valid), .cq_IsWr(cq_IsWr), .cq_Addr(cq_Addr),
    .cq_TID(cq_TID), .cq_Len(cq_Len), .cq_Sop(cq_Sop), .cq_Data(cq_Data),
    .rd_RspValid(rd_RspValid), .sch_RdPend(sch_RdPend)
  );

  initial begin
    Clk_400 = 1'b0;
    forever #5 Clk_400 = ~Clk_400;
  end

  int testCount = 0;
  int failCount = 0;

  // Model: credits in flight, remaining locked beats, whose turn it is and the streak length.
  int  mPend = 0, mBeats = 0, mCnt = 0;
  bit  mLocked = 0, mPtrWr = 0, mBoth = 0, gRd = 0, gWr = 0;

  bit                  eValid = 0, eIsWr = 0, eSop = 0, eFieldsCheck = 0;
  logic [ADDR_LMT-1:0] eAddr = '0;
  logic [15:0]         eTid = '0;
  logic [1:0]          eLen = '0;
  logic [511:0]        eData = '0;

  bit       lastRd, lastWr;
  logic [7:0] rdPatt, wrPatt;
  int       rdCnt, wrCnt;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int rst, input int rdEn, input int rdAddr, input int rdLen,
                               input int wrEn, input int wrSop, input int wrLen,
                               input int almFull, input int rsp);
    SoftReset    = 1'(rst);
    rw2ab_RdEn   = 1'(rdEn);
    rw2ab_RdAddr = ADDR_LMT'(rdAddr);
    rw2ab_RdLen  = 2'(rdLen);
    rw2ab_RdTID  = 16'($urandom);
    rw2ab_WrEn   = 1'(wrEn);
    rw2ab_WrSop  = 1'(wrSop);
    rw2ab_WrLen  = 2'(wrLen);
    rw2ab_WrAddr = ADDR_LMT'($urandom);
    rw2ab_WrTID  = 16'($urandom);
    for (int i = 0; i < 16; i++) rw2ab_WrDin[i*32 +: 32] = $urandom;
    cq_AlmFull   = 1'(almFull);
    rd_RspValid  = 1'(rsp);
  endtask

  task automatic modelDecide();
    bit rdE, wrE;
    gRd = 0; gWr = 0; mBoth = 0;
    if (SoftReset) return;
    if (mLocked) begin
      gWr = rw2ab_WrEn && !cq_AlmFull;
    end else begin
      rdE   = rw2ab_RdEn && !cq_AlmFull && (mPend + int'(rw2ab_RdLen) + 1 <= MAXP);
      wrE   = rw2ab_WrEn && rw2ab_WrSop && !cq_AlmFull;
      mBoth = rdE && wrE;
      if (mBoth) begin
        gRd = !mPtrWr;
        gWr = mPtrWr;
      end else begin
        gRd = rdE;
        gWr = wrE;
      end
    end
  endtask

  task automatic modelUpdate();
    int oldPend;
    if (SoftReset) begin
      mPend = 0; mLocked = 0; mBeats = 0; mPtrWr = 0; mCnt = 0;
      eValid = 0; eIsWr = 0; eAddr = '0; eTid = '0; eLen = '0; eSop = 0; eData = '0;
      eFieldsCheck = 1;
      return;
    end
    eFieldsCheck = 0;
    eValid = gRd || gWr;
    if (gRd) begin
      eIsWr = 0; eAddr = rw2ab_RdAddr; eTid = rw2ab_RdTID; eLen = rw2ab_RdLen;
      eSop = 1; eData = '0;
    end else if (gWr) begin
      eIsWr = 1; eAddr = rw2ab_WrAddr; eTid = rw2ab_WrTID; eLen = rw2ab_WrLen;
      eSop = !mLocked; eData = rw2ab_WrDin;
    end
    oldPend = mPend;
    if (rd_RspValid && oldPend > 0) mPend--;
    if (gRd) mPend += int'(rw2ab_RdLen) + 1;
    if (mLocked) begin
      if (gWr) begin
        mBeats--;
        if (mBeats == 0) mLocked = 0;
      end
    end else if (gRd || gWr) begin
      if (mBoth) begin
        mCnt++;
        if (mCnt >= (gWr ? WRW : RDW)) begin
          mPtrWr = !mPtrWr;
          mCnt = 0;
        end
      end else begin
        mPtrWr = gRd;
        mCnt = 1;
      end
      if (gWr && rw2ab_WrLen != 2'd0) begin
        mLocked = 1;
        mBeats = int'(rw2ab_WrLen);
      end
    end
  endtask

  task automatic runCycle();
    @(negedge Clk_400);
    modelDecide();
    lastRd = ab2rw_RdSent;
    lastWr = ab2rw_WrSent;
    checkOutput("RdSent", 512'(ab2rw_RdSent), 512'(gRd));
    checkOutput("WrSent", 512'(ab2rw_WrSent), 512'(gWr));
    checkOutput("WrAlmFull", 512'(ab2rw_WrAlmFull), 512'(cq_AlmFull));
    checkOutput("RdPend", 512'(sch_RdPend), 512'(mPend));
    checkOutput("cqValid", 512'(cq_Valid), 512'(eValid));
    if (eValid || eFieldsCheck) begin
      checkOutput("cqIsWr", 512'(cq_IsWr), 512'(eIsWr));
      checkOutput("cqAddr", 512'(cq_Addr), 512'(eAddr));
      checkOutput("cqTID", 512'(cq_TID), 512'(eTid));
      checkOutput("cqLen", 512'(cq_Len), 512'(eLen));
      checkOutput("cqSop", 512'(cq_Sop), 512'(eSop));
      checkOutput("cqData", cq_Data, eData);
    end
    @(posedge Clk_400);
    modelUpdate();
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk_400);
    modelUpdate();
    #1;
    runCycle();

    // Three single-CL reads, then their responses.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, i, 0, 0, 0, 0, 0, 0);
      runCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t1Pend3", 512'(sch_RdPend), 512'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      runCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t1Pend0", 512'(sch_RdPend), 512'd0);

    // Both streams continuous after reset: R,R,W,W,R,R,W,W.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 16 + i, 0, 1, 1, 0, 0, 0);
      runCycle();
      rdPatt[i] = lastRd;
      wrPatt[i] = lastWr;
    end
    checkOutput("t2RdPattern", 512'(rdPatt), 512'(8'b00110011));
    checkOutput("t2WrPattern", 512'(wrPatt), 512'(8'b11001100));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      runCycle();
    end

    // Lone read hands the turn to writes; 4-beat packet with a bubble then blocks reads.
    applyStimulus(0, 1, 32, 0, 0, 0, 0, 0, 0);
    runCycle();
    rdCnt = 0; wrCnt = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 33, 0, (i == 2) ? 0 : 1, (i == 0) ? 1 : 0, 3, 0, 0);
      runCycle();
      rdCnt += int'(lastRd);
      wrCnt += int'(lastWr);
    end
    checkOutput("t3WrBeats", 512'(wrCnt), 512'd4);
    checkOutput("t3RdBlocked", 512'(rdCnt), 512'd0);
    applyStimulus(0, 1, 33, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t3RdAfter", 512'(lastRd), 512'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    runCycle();
    checkOutput("orphanBeat", 512'(lastWr), 512'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      runCycle();
    end
    checkOutput("t3PendZero", 512'(sch_RdPend), 512'd0);

    // Credit limit: 2-CL reads fill 8 credits, responses release them one by one.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 64 + i, 1, 0, 0, 0, 0, 0);
      runCycle();
    end
    checkOutput("t4Stall", 512'(lastRd), 512'd0);
    checkOutput("t4PendFull", 512'(sch_RdPend), 512'd8);
    applyStimulus(0, 1, 70, 1, 0, 0, 0, 0, 1);
    runCycle();
    checkOutput("t4OneRsp", 512'(lastRd), 512'd0);
    runCycle();
    checkOutput("t4TwoRsp", 512'(lastRd), 512'd0);
    applyStimulus(0, 1, 71, 1, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t4Release", 512'(lastRd), 512'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();

    // Almost-full blocks everything, issue resumes right after.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 80, 1, 1, 1, 0, 1, 0);
      runCycle();
      checkOutput("t5NoSent", 512'(lastRd | lastWr), 512'd0);
    end
    applyStimulus(0, 1, 80, 1, 1, 1, 0, 0, 0);
    runCycle();
    checkOutput("t5Resume", 512'(lastWr), 512'd1);

    // Reset inside a locked packet with credits outstanding.
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 0, 0);
    runCycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 2, 0, 0);
    runCycle();
    checkOutput("t6PendClr", 512'(sch_RdPend), 512'd0);
    checkOutput("t6ValidClr", 512'(cq_Valid), 512'd0);
    applyStimulus(0, 1, 90, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t6ReadIssues", 512'(lastRd), 512'd1);

    // Random traffic, including protocol-error beats and occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2) ? 1 : 0,
                    ($urandom_range(0, 99) < 60) ? 1 : 0, int'($urandom), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 60) ? 1 : 0, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 15) ? 1 : 0,
                    ($urandom_range(0, 99) < 40) ? 1 : 0);
      runCycle();
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/cmdq_rdwr_sched.md
Name: cmdq_rdwr_sched

Overview:
- Schedules the read and write request streams of one NLB test engine onto a single shared CCI-P command-queue issue port.
- Returns per-stream Sent handshakes to the engine.
- Arbitration is weighted round-robin and never splits a multi-CL write packet.
- Throttles reads against an outstanding-CL credit limit, and all issue against downstream almost-full.
- Sits between the test engine and the command-queue FIFO.

Parameters:
- ADDR_LMT, 20, request address width.
- RD_WEIGHT, 2, max consecutive read grants while writes are waiting (1..15).
- WR_WEIGHT, 2, max consecutive write packets while reads are waiting (1..15).
- MAX_RD_PEND, 512, max outstanding read cache lines (≤ 2047).

Ports:
- Clk_400  in  1  core clock.
- SoftReset  in  1  synchronous, active-high reset.
- rw2ab_RdEn  in  1  read request valid.
- rw2ab_RdAddr  in  ADDR_LMT  read address.
- rw2ab_RdTID  in  16  read metadata.
- rw2ab_RdLen  in  2  read length; CLs = RdLen+1.
- ab2rw_RdSent  out  1  read accepted this cycle (combinational).
- rw2ab_WrEn  in  1  write request valid.
- rw2ab_WrAddr  in  ADDR_LMT  write address.
- rw2ab_WrTID  in  16  write metadata.
- rw2ab_WrDin  in  512  write data.
- rw2ab_WrLen  in  2  packet length on Sop beat; beats = WrLen+1.
- rw2ab_WrSop  in  1  first beat of write packet.
- ab2rw_WrSent  out  1  write beat accepted this cycle (combinational).
- ab2rw_WrAlmFull  out  1  equals cq_AlmFull.
- cq_AlmFull  in  1  command queue almost full.
- cq_Valid  out  1  command valid (registered).
- cq_IsWr  out  1  1 = write, 0 = read.
- cq_Addr  out  ADDR_LMT  command address.
- cq_TID  out  16  command metadata.
- cq_Len  out  2  command length.
- cq_Sop  out  1  start of packet (always 1 for reads).
- cq_Data  out  512  write data; 0 for reads.
- rd_RspValid  in  1  one read CL returned.
- sch_RdPend  out  11  outstanding read CL count.

Behaviour:
- Clock and reset: one clock, Clk_400. Reset is synchronous, active-high, on SoftReset.
- Reset values:
  - cq_Valid, cq_IsWr, cq_Addr, cq_TID, cq_Len, cq_Sop, cq_Data = 0.
  - sch_RdPend = 0.
  - FSM = ARB, weight counter = 0, priority pointer = READ.
  - Reset mid-packet discards the lock and any pending credits.
- Issue eligibility (cycle-level):
  - rd_ok = RdEn & !cq_AlmFull & (RdPend + RdLen + 1 ≤ MAX_RD_PEND) & state==ARB.
  - wr_ok = WrEn & !cq_AlmFull.
  - In ARB, a write is only granted on a Sop beat. WrEn with WrSop=0 in ARB is a protocol error: ignore it, never grant it.
- Sent strobes and output register:
  - At most one grant per cycle.
  - RdSent/WrSent are asserted combinationally in the grant cycle.
  - The cq_* register loads the granted request at the next edge, so latency is 1 cycle.
  - cq_Valid is 0 in any cycle after no grant.
- FSM:
  - ARB: select between rd_ok and wr_ok (Sop).
    - Write grant with WrLen≠0: go to WR_LOCK, beats_left = WrLen.
    - Write grant with WrLen=0: stay in ARB.
  - WR_LOCK: only writes are granted. Each grant decrements beats_left; at beats_left==0 on a grant, return to ARB. Reads stall, even when the write stream bubbles or cq_AlmFull is high.
- Arbitration:
  - Both eligible: grant the pointer side. Increment the weight counter per read grant or per write packet (counted on the Sop grant).
  - When the counter reaches the side's weight and the other side is eligible: flip the pointer and clear the counter.
  - Only one side eligible: grant it and flip the pointer to the other side; counter = 1.
- Credit counter (11-bit):
  - Read grant adds RdLen+1; rd_RspValid subtracts 1. Both in the same cycle: net RdLen.
  - The counter never underflows: rd_RspValid at 0 is ignored.
- ab2rw_WrAlmFull = cq_AlmFull, passed through combinationally.

Test Plan:
- Reads only, RdLen=0, 3 requests, cq_AlmFull=0 → RdSent on 3 consecutive cycles; cq_Valid 1 cycle later with IsWr=0, Addr 0,1,2; sch_RdPend=3; 3 responses return it to 0.
- Both streams continuous, single-CL, weights 2/2 → grant pattern R,R,W,W,R,R,W,W; reads granted first after reset.
- Write packet WrLen=3 (4 beats) with RdEn held high → 4 consecutive WrSent with cq_Sop=1,0,0,0; no RdSent until after the 4th beat; WrEn bubble mid-packet still blocks reads.
- MAX_RD_PEND=4, RdLen=1 → 2 reads granted, third stalls with RdPend=4; a single rd_RspValid still blocks (3+2>4); second response releases it.
- cq_AlmFull high for 5 cycles with both requests valid → no Sent, cq_Valid=0, ab2rw_WrAlmFull=1; issue resumes the cycle after deassert.
- SoftReset pulsed during WR_LOCK with RdPend=7 → next cycle FSM=ARB, sch_RdPend=0, cq_Valid=0; a read then issues normally.
